// File: rtl/cgia_pkg.sv
// Shared definitions for the CGIA memory-port arbiter and debug register block.
package cgia_pkg;

    // Width of the CPU starvation counter.
    localparam int STARVE_W = 8;

    // Bus owner encoding. The value 3 is not a legal owner and is treated as idle.
    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_VIDEO = 2'd1,
        OWN_CPU   = 2'd2
    } owner_t;

endpackage

// File: rtl/cgia_starve_ctr.sv
// Saturating wait counter for the CPU. It counts denied cycles and flags when
// the CPU has waited long enough to take the next video word boundary.
module cgia_starve_ctr
    import cgia_pkg::*;
#(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam logic [STARVE_W-1:0] LIM = STARVE_W'(LIMIT);

    logic [STARVE_W-1:0] r_count;
    logic                w_at_limit;

    assign w_at_limit = (r_count == LIM);
    assign o_at_limit = w_at_limit;

    // Clear has priority; otherwise count up and hold at the limit.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_limit) begin
            r_count <= r_count + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/cgia_bus_arbiter.sv
// Two-master Wishbone arbiter for the CGIA memory port. Video has priority;
// the CPU gets one transfer at a video word boundary once it has starved.
//
// Handshake: a Wishbone transfer completes in a cycle where the owner's cyc
// (and stb) are high and the slave's ack_i is high. The slave outputs are a
// pure function of the registered owner and the owner's request signals, so
// ack_i never feeds back into cyc_o/stb_o/adr_o combinationally. An ack that
// arrives while the owner has dropped cyc is discarded.
module cgia_bus_arbiter
    import cgia_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    // Video fetcher
    input  logic        v_cyc_i,
    input  logic [22:0] v_adr_i,
    output logic        v_ack_o,
    output logic [15:0] v_dat_o,
    // Host CPU
    input  logic        c_cyc_i,
    input  logic        c_stb_i,
    input  logic        c_we_i,
    input  logic [22:0] c_adr_i,
    input  logic [1:0]  c_sel_i,
    input  logic [15:0] c_dat_i,
    output logic [15:0] c_dat_o,
    output logic        c_ack_o,
    // Memory slave
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [22:0] adr_o,
    output logic [1:0]  sel_o,
    output logic [15:0] dat_o,
    input  logic [15:0] dat_i,
    input  logic        ack_i,
    // Debug: current owner
    output logic [1:0]  owner_o
);

    owner_t r_owner;
    logic   w_at_limit;
    logic   w_is_video;
    logic   w_is_cpu;

    assign w_is_video = (r_owner == OWN_VIDEO);
    assign w_is_cpu   = (r_owner == OWN_CPU);

    cgia_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .i_inc     (c_cyc_i && !w_is_cpu),
        .i_clr     (w_is_cpu || !c_cyc_i),
        .o_at_limit(w_at_limit)
    );

    // Owner FSM: video wins ties, handovers happen only on acked words or dropped cyc.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_owner <= OWN_IDLE;
        end else begin
            case (r_owner)
                OWN_VIDEO: begin
                    if (!v_cyc_i) begin
                        r_owner <= c_cyc_i ? OWN_CPU : OWN_IDLE;
                    end else if (ack_i && w_at_limit && c_cyc_i) begin
                        r_owner <= OWN_CPU;
                    end
                end
                OWN_CPU: begin
                    if (!c_cyc_i) begin
                        r_owner <= v_cyc_i ? OWN_VIDEO : OWN_IDLE;
                    end else if (ack_i && v_cyc_i) begin
                        r_owner <= OWN_VIDEO;
                    end
                end
                default: begin
                    if (v_cyc_i) begin
                        r_owner <= OWN_VIDEO;
                    end else if (c_cyc_i) begin
                        r_owner <= OWN_CPU;
                    end else begin
                        r_owner <= OWN_IDLE;
                    end
                end
            endcase
        end
    end

    // Slave-side mux selected only by the registered owner.
    always_comb begin
        cyc_o = 1'b0;
        stb_o = 1'b0;
        we_o  = 1'b0;
        adr_o = '0;
        sel_o = '0;
        dat_o = '0;
        case (r_owner)
            OWN_VIDEO: begin
                cyc_o = v_cyc_i;
                stb_o = v_cyc_i;
                sel_o = 2'b11;
                adr_o = v_adr_i;
            end
            OWN_CPU: begin
                cyc_o = c_cyc_i;
                stb_o = c_stb_i;
                we_o  = c_we_i;
                adr_o = c_adr_i;
                sel_o = c_sel_i;
                dat_o = c_dat_i;
            end
            default: begin
                cyc_o = 1'b0;
            end
        endcase
    end

    assign v_ack_o = ack_i && w_is_video && v_cyc_i;
    assign c_ack_o = ack_i && w_is_cpu && c_cyc_i && c_stb_i;
    assign v_dat_o = dat_i;
    assign c_dat_o = dat_i;
    assign owner_o = r_owner;

endmodule

// File: tb/tb_cgia_bus_arbiter.sv
// Directed bench for cgia_bus_arbiter. The driver sets inputs shortly after
// each rising edge and queues the hand-computed outputs for that cycle; the
// monitor compares them on the falling edge.
module tb_cgia_bus_arbiter;

    localparam int W = 80;
    localparam logic [22:0] VA = 23'h7F8000;   // $FF0000 >> 1

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        v_cyc_i = 1'b0;
    logic [22:0] v_adr_i = '0;
    logic        v_ack_o;
    logic [15:0] v_dat_o;
    logic        c_cyc_i = 1'b0, c_stb_i = 1'b0, c_we_i = 1'b0;
    logic [22:0] c_adr_i = '0;
    logic [1:0]  c_sel_i = '0;
    logic [15:0] c_dat_i = '0;
    logic [15:0] c_dat_o;
    logic        c_ack_o;
    logic        cyc_o, stb_o, we_o;
    logic [22:0] adr_o;
    logic [1:0]  sel_o;
    logic [15:0] dat_o;
    logic [15:0] dat_i = '0;
    logic        ack_i = 1'b0;
    logic [1:0]  owner_o;

    cgia_bus_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .v_cyc_i(v_cyc_i), .v_adr_i(v_adr_i), .v_ack_o(v_ack_o), .v_dat_o(v_dat_o),
        .c_cyc_i(c_cyc_i), .c_stb_i(c_stb_i), .c_we_i(c_we_i), .c_adr_i(c_adr_i),
        .c_sel_i(c_sel_i), .c_dat_i(c_dat_i), .c_dat_o(c_dat_o), .c_ack_o(c_ack_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .owner_o(owner_o)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    // Scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    function automatic logic [W-1:0] pk(logic [1:0] own, logic cyc, logic stb, logic we,
                                        logic [1:0] sel, logic [22:0] adr, logic [15:0] dat,
                                        logic vack, logic cack, logic [15:0] cdat,
                                        logic [15:0] vdat);
        return {own, cyc, stb, we, sel, adr, dat, vack, cack, cdat, vdat};
    endfunction

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = pk(owner_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
                    v_ack_o, c_ack_o, c_dat_o, v_dat_o);
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s: got {own,cyc,stb,we,sel,adr,dat,vack,cack,cdat,vdat}=%h required %h",
                         nm, a, e);
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(string nm, logic [1:0] own, logic cyc, logic stb, logic we,
                        logic [1:0] sel, logic [22:0] adr, logic [15:0] dat,
                        logic vack, logic cack);
        exp_q.push_back(pk(own, cyc, stb, we, sel, adr, dat, vack, cack, dat_i, dat_i));
        name_q.push_back(nm);
    endtask

    task automatic exp_zero(string nm);
        push(nm, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 23'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic exp_vid(string nm, logic cyc, logic [22:0] adr, logic vack);
        push(nm, 2'd1, cyc, cyc, 1'b0, 2'b11, adr, 16'h0, vack, 1'b0);
    endtask

    task automatic exp_cpu(string nm, logic cyc, logic stb, logic we, logic [1:0] sel,
                           logic [22:0] adr, logic [15:0] dat, logic cack);
        push(nm, 2'd2, cyc, stb, we, sel, adr, dat, 1'b0, cack);
    endtask

    initial begin
        // Reset held with both masters requesting and a stray ack.
        v_cyc_i = 1'b1; v_adr_i = VA;
        c_cyc_i = 1'b1; c_stb_i = 1'b1;
        ack_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            exp_zero("reset_hold");
        end

        // Release: still idle this cycle, both request, video must win.
        step();
        reset_i = 1'b1; ack_i = 1'b0;
        exp_zero("reset_release_idle");

        step();
        ack_i = 1'b1;
        exp_vid("tie_video_wins", 1'b1, VA, 1'b1);

        // CPU withdraws, clearing its wait count.
        step();
        c_cyc_i = 1'b0; c_stb_i = 1'b0; v_adr_i = VA + 23'd1;
        exp_vid("video_stream", 1'b1, VA + 23'd1, 1'b1);

        // CPU write waits while video streams with zero-wait acks.
        for (int i = 0; i < 9; i++) begin
            step();
            c_cyc_i = 1'b1; c_stb_i = 1'b1; c_we_i = 1'b1;
            c_adr_i = 23'h000080; c_dat_i = 16'hBEEF; c_sel_i = 2'b11;
            v_adr_i = VA + 23'(2 + i);
            exp_vid("starve_wait", 1'b1, VA + 23'(2 + i), 1'b1);
        end

        // Granted right after the 9th ack; the fetcher holds its address.
        step();
        exp_cpu("preempt_cpu_write", 1'b1, 1'b1, 1'b1, 2'b11, 23'h000080, 16'hBEEF, 1'b1);

        // Handback to video with no gap.
        step();
        c_cyc_i = 1'b0; c_stb_i = 1'b0; c_we_i = 1'b0;
        exp_vid("handback_video", 1'b1, VA + 23'd10, 1'b1);

        // Video aborts on an acked cycle while the CPU waits.
        step();
        v_cyc_i = 1'b0;
        c_cyc_i = 1'b1; c_stb_i = 1'b1; c_we_i = 1'b0;
        c_adr_i = 23'h012345; c_sel_i = 2'b01; c_dat_i = 16'h0000;
        exp_vid("video_abort_to_cpu", 1'b0, VA + 23'd10, 1'b0);

        // CPU read with three wait-states.
        for (int i = 0; i < 3; i++) begin
            step();
            ack_i = 1'b0;
            exp_cpu("cpu_wait_state", 1'b1, 1'b1, 1'b0, 2'b01, 23'h012345, 16'h0, 1'b0);
        end
        step();
        ack_i = 1'b1; dat_i = 16'h1234;
        exp_cpu("cpu_read_ack", 1'b1, 1'b1, 1'b0, 2'b01, 23'h012345, 16'h0, 1'b1);

        // CPU ends its cycle; owner returns to idle next.
        step();
        ack_i = 1'b0; dat_i = 16'h0000;
        c_cyc_i = 1'b0; c_stb_i = 1'b0;
        exp_cpu("cpu_release", 1'b0, 1'b0, 1'b0, 2'b01, 23'h012345, 16'h0, 1'b0);

        step();
        v_cyc_i = 1'b1; v_adr_i = VA;
        exp_zero("idle_after_cpu");

        step();
        ack_i = 1'b1;
        exp_vid("video_again", 1'b1, VA, 1'b1);

        // Abort with no CPU request: ack dropped, then idle.
        step();
        v_cyc_i = 1'b0;
        exp_vid("video_abort_to_idle", 1'b0, VA, 1'b0);

        step();
        ack_i = 1'b0;
        c_cyc_i = 1'b1; c_stb_i = 1'b1; c_we_i = 1'b1;
        c_adr_i = 23'h000555; c_sel_i = 2'b10; c_dat_i = 16'hA5A5;
        exp_zero("idle_after_abort");

        step();
        exp_cpu("cpu_from_idle", 1'b1, 1'b1, 1'b1, 2'b10, 23'h000555, 16'hA5A5, 1'b0);

        // Reset mid-transfer: everything drops within the same cycle.
        step();
        ack_i = 1'b1;
        reset_i = 1'b0;
        exp_zero("reset_mid_transfer");

        step();
        reset_i = 1'b1; ack_i = 1'b0;
        n_vec++;
        if (dut.u_starve.r_count !== 8'd0) begin
            n_err++;
            $display("FAIL starve_count_after_reset: got %0d required 0", dut.u_starve.r_count);
        end
        exp_zero("idle_after_reset");

        step();
        ack_i = 1'b1;
        exp_cpu("cpu_after_reset", 1'b1, 1'b1, 1'b1, 2'b10, 23'h000555, 16'hA5A5, 1'b1);

        step();
        ack_i = 1'b0; c_cyc_i = 1'b0; c_stb_i = 1'b0; c_we_i = 1'b0;
        exp_cpu("cpu_done", 1'b0, 1'b0, 1'b0, 2'b10, 23'h000555, 16'hA5A5, 1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk_i);
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
